dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single-port data memory between the two load/store slots (lanes 3/4) of each VLIW bundle.
// - Sits between the decode-stage outputs (dec_mre*/dec_mwe*/daddr*/dec_rd*) and the BRAM.
// - Serialises dual accesses in program order (lane 3 first) and stalls the pipeline for the extra cycle.
// - Returns load data as wb_memdata3/4 with wb_rd3/4 for register-file writeback.
// PARAMETERS
// - RD_LAT  1  BRAM read latency in cycles (issue -> mem_rdata valid); supported values 1, 2
// - AW      30 data address width
// PORTS
// - clk          in   1   clock (single clock domain)
// - rst          in   1   reset, synchronous, active-high
// - stall        in   1   pipeline stall from sources other than this block; exec bundle held while high
// - dec_mre3     in   1   lane 3 load
// - dec_mwe3     in   1   lane 3 store
// - daddr3       in   AW  lane 3 address
// - wdata3       in   32  lane 3 store data
// - dec_rd3      in   7   lane 3 load destination {fp, idx}
// - dec_mre4/dec_mwe4/daddr4/wdata4/dec_rd4  same for lane 4
// - mem_en       out  1   BRAM enable
// - mem_we       out  1   BRAM write enable
// - mem_addr     out  AW  BRAM address
// - mem_wdata    out  32  BRAM write data
// - mem_rdata    in   32  BRAM read data, valid RD_LAT cycles after issue
// - mem_stall    out  1   combinational: hold pipeline this cycle
// - wb_memdata3  out  32  lane 3 load result
// - wb_memdata4  out  32  lane 4 load result
// - wb_rd3       out  7   lane 3 writeback destination, 0 = no write
// - wb_rd4       out  7   lane 4 writeback destination, 0 = no write
// BEHAVIOUR
// - Lane activity: act3 = dec_mre3|dec_mwe3; act4 = dec_mre4|dec_mwe4.
// - Inputs are stable while stall or mem_stall is high.
// - FSM states:
//   - IDLE:   a new bundle is in exec.
//     - act3&act4: issue lane 3, mem_stall=1, go to SECOND.
//     - Exactly one active: issue it; go to HOLD if stall, else stay IDLE.
//     - None active: no issue; stay IDLE.
//   - SECOND: issue lane 4, mem_stall=0; go to HOLD if stall, else IDLE.
//   - HOLD:   bundle already issued, pipeline still stalled; no issue; go to IDLE when stall=0.
// - Each access is issued exactly once per bundle, however long stall lasts.
// - Issue: mem_en=1, mem_we=lane mwe, mem_addr/mem_wdata from that lane.
//   - Non-issue cycles: mem_en=0, mem_we=0; addr/wdata don't-care (drive 0).
// - Ordering: lane 3 store + lane 4 load to the same address; lane 4 reads the new data (sequential cycles).
// - Load return: single load issued in cycle t -> wb_* registered from mem_rdata, visible in cycle t+RD_LAT+1 only.
// - Dual bundle (lane 3 issued t, lane 4 issued t+1):
//   - Lane 3 data captured in a hold register at t+RD_LAT.
//   - wb_memdata3/4 and wb_rd3/4 both visible together in cycle t+RD_LAT+2.
// - wb_rd* is a one-cycle pulse: 0 in every other cycle and for stores. wb_memdata* holds its last value.
// - Writeback timing is independent of stall; in-flight loads always complete.
// - No flush input: the bundle in exec is older than any flushed instruction.
// - Reset (any cycle, including mid-pair):
//   - State IDLE; in-flight tags and hold register cleared.
//   - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, mem_stall, wb_memdata3/4, wb_rd3/4.
//   - mem_stall=0 is forced in the reset cycle.
// - Both lanes storing: two writes, lane 3 first; no writeback.
// STRUCTURE
// - Package dmem_arb_pkg:
//   - arb_state_t enum {IDLE, SECOND, HOLD}.
//   - mem_tag_t struct {valid, lane, rd[6:0], pair}.
//   - Localparam for supported RD_LAT range.
// - Sub-module dmem_tag_pipe: RD_LAT-deep shift register of mem_tag_t, synchronous reset.
//   - Tells the writeback stage which lane/rd each mem_rdata belongs to and whether to hold or emit.
// TESTING
// - Single load: act3 only, daddr3=0x10, mem[0x10]=0xDEADBEEF, dec_rd3=7'h05.
//   -> one issue, mem_stall=0, wb_rd3=5 and wb_memdata3=0xDEADBEEF at cycle t+RD_LAT+1, wb_rd4=0.
// - Dual load: lane 3 @0x20=0x11, lane 4 @0x24=0x22.
//   -> mem_stall=1 for exactly cycle t, addresses 0x20 then 0x24.
//   -> both wb pulses in the same cycle t+RD_LAT+2 with correct data/rd.
// - Store->load RAW: lane 3 sw 0xCAFE @0x30, lane 4 lw @0x30 rd=0x23.
//   -> write at t, read at t+1, wb_memdata4=0xCAFE, wb_rd3=0.
// - External stall: single load with stall=1 for 4 cycles.
//   -> mem_en high in exactly one cycle, FSM in HOLD, returns to IDLE when stall drops, one wb pulse.
// - Dual access with stall asserted during SECOND.
//   -> lane 4 issued once, FSM in HOLD until stall=0, no duplicate writes (check mem via write counter).
// - rst asserted in the SECOND cycle.
//   -> no lane 4 issue, all outputs 0 next cycle, no wb pulse from the aborted pair, normal operation after.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory port arbiter
package dmem_arb_pkg;

    // BRAM read latencies the tag pipeline and writeback alignment are built for
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Lane identifiers carried in the tag
    localparam logic LANE3 = 1'b0;
    localparam logic LANE4 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SECOND = 2'd1,
        HOLD   = 2'd2
    } arb_state_t;

    // One entry per issued access that matters to writeback.
    // rd is zero for stores so a paired store still marks its slot.
    typedef struct packed {
        logic       valid;
        logic       lane;
        logic [6:0] rd;
        logic       pair;
    } mem_tag_t;

    function automatic mem_tag_t make_tag(input logic       valid,
                                          input logic       lane,
                                          input logic [6:0] rd,
                                          input logic       pair);
        mem_tag_t t;
        t.valid = valid;
        t.lane  = lane;
        t.rd    = rd;
        t.pair  = pair;
        return t;
    endfunction

endpackage

// File: rtl/dmem_tag_pipe.sv
// rtl/dmem_tag_pipe.sv - delay line aligning access tags with BRAM read data
module dmem_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 1
)
(
    input  logic     clk,
    input  logic     rst,
    input  mem_tag_t tag_i,
    output mem_tag_t tag_o
);

    mem_tag_t stage_q [DEPTH];

    // Shift the issue-time tag so it emerges in the cycle mem_rdata is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - serialises the two load/store lanes onto one BRAM port
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 30
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          dec_mre3,
    input  logic          dec_mwe3,
    input  logic [AW-1:0] daddr3,
    input  logic [31:0]   wdata3,
    input  logic [6:0]    dec_rd3,
    input  logic          dec_mre4,
    input  logic          dec_mwe4,
    input  logic [AW-1:0] daddr4,
    input  logic [31:0]   wdata4,
    input  logic [6:0]    dec_rd4,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          mem_stall,
    output logic [31:0]   wb_memdata3,
    output logic [31:0]   wb_memdata4,
    output logic [6:0]    wb_rd3,
    output logic [6:0]    wb_rd4
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("dmem_port_arbiter: unsupported RD_LAT %0d", RD_LAT);
    end

    arb_state_t    state_q, state_d;
    logic          act3, act4;
    logic          issue, issue_l4, pair, stall_req;
    logic          sel_mre, sel_mwe, sel_load;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [6:0]    sel_rd;
    mem_tag_t      tag_in, tag_out;

    logic [31:0]   hold_data_q;
    logic [6:0]    hold_rd_q;
    logic [31:0]   wb_memdata3_q, wb_memdata4_q;
    logic [6:0]    wb_rd3_q, wb_rd4_q;

    assign act3 = dec_mre3 | dec_mwe3;
    assign act4 = dec_mre4 | dec_mwe4;

    // Decide which lane (if any) owns the port this cycle and where the bundle goes next
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        issue_l4  = 1'b0;
        pair      = 1'b0;
        stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (act3 && act4) begin
                    issue     = 1'b1;
                    pair      = 1'b1;
                    stall_req = 1'b1;
                    state_d   = SECOND;
                end else if (act3 || act4) begin
                    issue    = 1'b1;
                    issue_l4 = ~act3;
                    state_d  = stall ? HOLD : IDLE;
                end
            end
            SECOND: begin
                issue    = 1'b1;
                issue_l4 = 1'b1;
                pair     = 1'b1;
                state_d  = stall ? HOLD : IDLE;
            end
            HOLD: begin
                state_d = stall ? HOLD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Reset aborts any pending lane-4 issue and releases the pipeline
        if (rst) begin
            issue     = 1'b0;
            stall_req = 1'b0;
            state_d   = IDLE;
        end
    end

    // Bundle sequencing state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign sel_mre   = issue_l4 ? dec_mre4 : dec_mre3;
    assign sel_mwe   = issue_l4 ? dec_mwe4 : dec_mwe3;
    assign sel_addr  = issue_l4 ? daddr4   : daddr3;
    assign sel_wdata = issue_l4 ? wdata4   : wdata3;
    assign sel_rd    = issue_l4 ? dec_rd4  : dec_rd3;
    assign sel_load  = sel_mre & ~sel_mwe;

    assign mem_en    = issue;
    assign mem_we    = issue & sel_mwe;
    assign mem_addr  = issue ? sel_addr  : '0;
    assign mem_wdata = issue ? sel_wdata : '0;
    assign mem_stall = stall_req;

    // Paired accesses always carry a tag so lane 4's slot can release lane 3's held data
    assign tag_in = make_tag(issue & (sel_load | pair), issue_l4,
                             sel_load ? sel_rd : 7'd0, pair);

    dmem_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Writeback: single loads emit at once, paired lane 3 waits in the hold register for lane 4
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_q   <= '0;
            hold_rd_q     <= '0;
            wb_memdata3_q <= '0;
            wb_memdata4_q <= '0;
            wb_rd3_q      <= '0;
            wb_rd4_q      <= '0;
        end else begin
            wb_rd3_q <= '0;
            wb_rd4_q <= '0;
            if (tag_out.valid) begin
                if (tag_out.lane == LANE3) begin
                    if (tag_out.pair) begin
                        hold_data_q <= mem_rdata;
                        hold_rd_q   <= tag_out.rd;
                    end else if (tag_out.rd != 7'd0) begin
                        wb_memdata3_q <= mem_rdata;
                        wb_rd3_q      <= tag_out.rd;
                    end
                end else begin
                    if (tag_out.pair && hold_rd_q != 7'd0) begin
                        wb_memdata3_q <= hold_data_q;
                        wb_rd3_q      <= hold_rd_q;
                    end
                    if (tag_out.rd != 7'd0) begin
                        wb_memdata4_q <= mem_rdata;
                        wb_rd4_q      <= tag_out.rd;
                    end
                end
            end
        end
    end

    assign wb_memdata3 = wb_memdata3_q;
    assign wb_memdata4 = wb_memdata4_q;
    assign wb_rd3      = wb_rd3_q;
    assign wb_rd4      = wb_rd4_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    localparam int RD_LAT = 1;
    localparam int AW     = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, stall;
    logic          dec_mre3, dec_mwe3, dec_mre4, dec_mwe4;
    logic [AW-1:0] daddr3, daddr4;
    logic [31:0]   wdata3, wdata4;
    logic [6:0]    dec_rd3, dec_rd4;
    logic          mem_en, mem_we, mem_stall;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata, wb_memdata3, wb_memdata4;
    logic [6:0]    wb_rd3, wb_rd4;

    dmem_port_arbiter #(.RD_LAT(RD_LAT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .dec_mre3(dec_mre3), .dec_mwe3(dec_mwe3), .daddr3(daddr3), .wdata3(wdata3), .dec_rd3(dec_rd3),
        .dec_mre4(dec_mre4), .dec_mwe4(dec_mwe4), .daddr4(daddr4), .wdata4(wdata4), .dec_rd4(dec_rd4),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .wb_memdata3(wb_memdata3), .wb_memdata4(wb_memdata4), .wb_rd3(wb_rd3), .wb_rd4(wb_rd4)
    );

    typedef struct {
        logic mre3, mwe3; logic [5:0] a3; logic [31:0] w3; logic [6:0] rd3;
        logic mre4, mwe4; logic [5:0] a4; logic [31:0] w4; logic [6:0] rd4;
    } bundle_t;

    int n_vec = 0, n_err = 0, cyc = 0, wr_count = 0, exp_writes = 0;
    bit wb_chk_en = 1'b0;

    logic [31:0] ref_mem [64];
    logic [6:0]  exp_rd3 [int];
    logic [6:0]  exp_rd4 [int];
    logic [31:0] exp_d3 [int];
    logic [31:0] exp_d4 [int];
    logic [6:0]  e_rd3, e_rd4;

    logic        pre_en;
    logic [5:0]  pre_a;
    logic [31:0] pre_d;
    logic [31:0] bram [64];
    logic [31:0] rpipe [RD_LAT];

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM with RD_LAT-cycle read latency and a write counter
    always @(posedge clk) begin
        if (pre_en) bram[pre_a] <= pre_d;
        if (mem_en && mem_we) begin
            bram[mem_addr[5:0]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        rpipe[0] <= bram[mem_addr[5:0]];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[RD_LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Writeback pulses: expected only where the model scheduled them, zero elsewhere
    always @(negedge clk) begin
        if (wb_chk_en) begin
            e_rd3 = exp_rd3.exists(cyc) ? exp_rd3[cyc] : 7'd0;
            e_rd4 = exp_rd4.exists(cyc) ? exp_rd4[cyc] : 7'd0;
            check_eq("wb_rd3", wb_rd3, e_rd3);
            check_eq("wb_rd4", wb_rd4, e_rd4);
            if (e_rd3 != 7'd0) check_eq("wb_memdata3", wb_memdata3, exp_d3[cyc]);
            if (e_rd4 != 7'd0) check_eq("wb_memdata4", wb_memdata4, exp_d4[cyc]);
        end
    end

    task automatic clear_inputs();
        stall = 1'b0;
        dec_mre3 = 1'b0; dec_mwe3 = 1'b0; daddr3 = '0; wdata3 = '0; dec_rd3 = '0;
        dec_mre4 = 1'b0; dec_mwe4 = 1'b0; daddr4 = '0; wdata4 = '0; dec_rd4 = '0;
    endtask

    // kind: 0 none, 1 load, 2 store
    function automatic bundle_t mk(input int k3, input logic [5:0] a3, input logic [31:0] w3, input logic [6:0] rd3,
                                   input int k4, input logic [5:0] a4, input logic [31:0] w4, input logic [6:0] rd4);
        bundle_t b;
        b.mre3 = (k3 == 1); b.mwe3 = (k3 == 2); b.a3 = a3; b.w3 = w3; b.rd3 = rd3;
        b.mre4 = (k4 == 1); b.mwe4 = (k4 == 2); b.a4 = a4; b.w4 = w4; b.rd4 = rd4;
        return b;
    endfunction

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pre_a = a; pre_d = d; pre_en = 1'b1;
        ref_mem[a] = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_mem_en", mem_en, 32'd0);
            check_eq("idle_mem_stall", mem_stall, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // Present one bundle with external stall high for its first s cycles
    task automatic run_bundle(input bundle_t b, input int s);
        int t, n, d, wbc;
        bit act3, act4, dual, l4;
        logic [31:0] e3, e4;
        t = cyc;
        act3 = b.mre3 | b.mwe3;
        act4 = b.mre4 | b.mwe4;
        dual = act3 && act4;
        n = int'(act3) + int'(act4);
        dec_mre3 = b.mre3; dec_mwe3 = b.mwe3; daddr3 = AW'(b.a3); wdata3 = b.w3; dec_rd3 = b.rd3;
        dec_mre4 = b.mre4; dec_mwe4 = b.mwe4; daddr4 = AW'(b.a4); wdata4 = b.w4; dec_rd4 = b.rd4;
        stall = (s > 0);
        e3 = '0; e4 = '0;
        if (b.mwe3) begin ref_mem[b.a3] = b.w3; exp_writes++; end
        else if (b.mre3) e3 = ref_mem[b.a3];
        if (b.mwe4) begin ref_mem[b.a4] = b.w4; exp_writes++; end
        else if (b.mre4) e4 = ref_mem[b.a4];
        wbc = t + RD_LAT + (dual ? 2 : 1);
        if (b.mre3) begin exp_rd3[wbc] = b.rd3; exp_d3[wbc] = e3; end
        if (b.mre4) begin exp_rd4[wbc] = b.rd4; exp_d4[wbc] = e4; end
        d = dual ? 2 : 1;
        if (s + 1 > d) d = s + 1;
        for (int k = 0; k < d; k++) begin
            @(negedge clk);
            check_eq("mem_stall", mem_stall, 32'(dual && k == 0));
            check_eq("mem_en", mem_en, 32'(k < n));
            if (k < n) begin
                l4 = !(act3 && k == 0);
                check_eq("mem_addr", mem_addr, l4 ? b.a4 : b.a3);
                check_eq("mem_we", mem_we, l4 ? b.mwe4 : b.mwe3);
                if (l4 ? b.mwe4 : b.mwe3) check_eq("mem_wdata", mem_wdata, l4 ? b.w4 : b.w3);
            end
            @(posedge clk); #1;
            stall = (k + 1 < s);
        end
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k3, k4, s;
        logic [5:0] a3, a4;
        rst = 1'b1; pre_en = 1'b0; pre_a = '0; pre_d = '0;
        clear_inputs();
        dec_mre3 = 1'b1; dec_mre4 = 1'b1; daddr3 = 30'h20; daddr4 = 30'h24; dec_rd3 = 7'h01; dec_rd4 = 7'h02;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_stall", mem_stall, 32'd0);
        check_eq("rst_mem_en", mem_en, 32'd0);
        check_eq("rst_mem_we", mem_we, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_wb_rd3", wb_rd3, 32'd0);
        check_eq("rst_wb_rd4", wb_rd4, 32'd0);
        check_eq("rst_wb_memdata3", wb_memdata3, 32'd0);
        check_eq("rst_wb_memdata4", wb_memdata4, 32'd0);
        @(posedge clk); #1;
        wb_chk_en = 1'b1;

        for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
        preload(6'h10, 32'hDEADBEEF);
        preload(6'h20, 32'h00000011);
        preload(6'h24, 32'h00000022);

        run_bundle(mk(1, 6'h10, 32'h0, 7'h05, 0, 6'h0, 32'h0, 7'h0), 0);
        idle(3);
        run_bundle(mk(1, 6'h20, 32'h0, 7'h0A, 1, 6'h24, 32'h0, 7'h0B), 0);
        idle(3);
        run_bundle(mk(2, 6'h30, 32'h0000CAFE, 7'h0, 1, 6'h30, 32'h0, 7'h23), 0);
        idle(3);
        run_bundle(mk(1, 6'h10, 32'h0, 7'h05, 0, 6'h0, 32'h0, 7'h0), 4);
        idle(3);
        run_bundle(mk(2, 6'h08, 32'h12345678, 7'h0, 2, 6'h09, 32'h9ABCDEF0, 7'h0), 3);
        run_bundle(mk(1, 6'h08, 32'h0, 7'h11, 1, 6'h09, 32'h0, 7'h12), 0);
        idle(5);

        // Reset during the SECOND cycle of a dual load
        dec_mre3 = 1'b1; dec_mre4 = 1'b1; daddr3 = 30'h20; daddr4 = 30'h24; dec_rd3 = 7'h31; dec_rd4 = 7'h32;
        @(negedge clk);
        check_eq("abort_first_issue", mem_en, 32'd1);
        check_eq("abort_first_stall", mem_stall, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_no_lane4", mem_en, 32'd0);
        check_eq("abort_mem_stall", mem_stall, 32'd0);
        check_eq("abort_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check_eq("post_rst_mem_we", mem_we, 32'd0);
        check_eq("post_rst_wb_memdata3", wb_memdata3, 32'd0);
        check_eq("post_rst_wb_memdata4", wb_memdata4, 32'd0);
        @(posedge clk); #1;
        idle(4);
        run_bundle(mk(1, 6'h24, 32'h0, 7'h33, 0, 6'h0, 32'h0, 7'h0), 0);

        for (int i = 0; i < 300; i++) begin
            k3 = $urandom_range(0, 2);
            k4 = $urandom_range(0, 2);
            a3 = 6'($urandom_range(0, 15));
            a4 = 6'($urandom_range(0, 15));
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_bundle(mk(k3, a3, $urandom, 7'($urandom_range(1, 127)),
                          k4, a4, $urandom, 7'($urandom_range(1, 127))), s);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(6);
        check_eq("write_count", wr_count, exp_writes);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
